// File: rtl/nx_indirect_access_mt_cntrl_if.sv
// CSR command/status port and shared SRAM software port of the indirect-access controller.
// The slave modport is the controller's view; the master modport is the CSR host / memory side.
interface nx_indirect_access_mt_cntrl_if #(
    parameter int N_REG_ADDR_BITS = 11,
    parameter int N_TABLES        = 4,
    parameter int N_ENTRIES       = 1024,
    parameter int N_DATA_BITS     = 64
);
    localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1;
    localparam int AW = $clog2(N_ENTRIES);

    logic                       wr_stb;
    logic [N_REG_ADDR_BITS-1:0] reg_addr;
    logic [3:0]                 cmnd_op;
    logic [AW-1:0]              cmnd_addr;
    logic [TW-1:0]              cmnd_table_id;
    logic [N_TABLES*AW-1:0]     addr_limit;
    logic [N_DATA_BITS-1:0]     wr_dat;
    logic [N_DATA_BITS-1:0]     rd_dat;
    logic [2:0]                 stat_code;
    logic [TW-1:0]              stat_table_id;
    logic [AW-1:0]              stat_addr;
    logic                       enable;
    logic                       sw_cs;
    logic                       sw_we;
    logic [TW-1:0]              sw_tid;
    logic [AW-1:0]              sw_add;
    logic [N_DATA_BITS-1:0]     sw_wdat;
    logic [N_DATA_BITS-1:0]     sw_rdat;
    logic                       grant;
    logic                       yield;

    modport slave (
        input  wr_stb, reg_addr, cmnd_op, cmnd_addr, cmnd_table_id, addr_limit, wr_dat,
               sw_rdat, grant,
        output rd_dat, stat_code, stat_table_id, stat_addr, enable,
               sw_cs, sw_we, sw_tid, sw_add, sw_wdat, yield
    );

    modport master (
        output wr_stb, reg_addr, cmnd_op, cmnd_addr, cmnd_table_id, addr_limit, wr_dat,
               sw_rdat, grant,
        input  rd_dat, stat_code, stat_table_id, stat_addr, enable,
               sw_cs, sw_we, sw_tid, sw_add, sw_wdat, yield
    );
endinterface

// File: rtl/nx_indirect_access_mt_cntrl.sv
// Indirect-access controller: sequences CSR-issued reads, writes, range fills and table resets
// onto one shared SRAM software port, with grant arbitration and a stall watchdog.
module nx_indirect_access_mt_cntrl #(
    parameter int                         N_REG_ADDR_BITS = 11,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS    = 11'h40C,
    parameter int                         N_TABLES        = 4,
    parameter int                         N_ENTRIES       = 1024,
    parameter int                         N_DATA_BITS     = 64,
    parameter int                         N_TIMER_BITS    = 4,
    parameter int                         N_INIT_INC_BITS = 8,
    parameter logic [N_DATA_BITS-1:0]     RESET_DATA      = {N_DATA_BITS{1'b0}}
) (
    input logic                          clk,
    input logic                          rst_n,
    nx_indirect_access_mt_cntrl_if.slave io
);
    localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1;
    localparam int AW = $clog2(N_ENTRIES);

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_READ      = 4'd1;
    localparam logic [3:0] OP_WRITE     = 4'd2;
    localparam logic [3:0] OP_ENABLE    = 4'd3;
    localparam logic [3:0] OP_DISABLE   = 4'd4;
    localparam logic [3:0] OP_RESET     = 4'd5;
    localparam logic [3:0] OP_INIT      = 4'd6;
    localparam logic [3:0] OP_INIT_INC  = 4'd7;
    localparam logic [3:0] OP_SET_START = 4'd8;
    localparam logic [3:0] OP_SIM_TMO   = 4'd14;
    localparam logic [3:0] OP_ACK_ERROR = 4'd15;

    localparam logic [2:0] ST_RDY = 3'd0;
    localparam logic [2:0] ST_BSY = 3'd1;
    localparam logic [2:0] ST_TMO = 3'd2;
    localparam logic [2:0] ST_OVR = 3'd3;
    localparam logic [2:0] ST_NXM = 3'd4;
    localparam logic [2:0] ST_UOP = 3'd5;
    localparam logic [2:0] ST_PDN = 3'd7;

    localparam logic [1:0] MODE_RESET = 2'd0;
    localparam logic [1:0] MODE_INIT  = 2'd1;
    localparam logic [1:0] MODE_INC   = 2'd2;

    typedef enum logic [2:0] {
        POWERDOWN = 3'd0,
        READY     = 3'd1,
        DO_READ   = 3'd2,
        READ_DONE = 3'd3,
        DO_WRITE  = 3'd4,
        DO_FILL   = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t                   r_state;
    state_t                   w_nxt_state;
    logic [2:0]               r_err_code;
    logic [2:0]               w_nxt_err;
    logic [2:0]               r_stat;
    logic                     r_sw_cs;
    logic                     r_sw_we;
    logic                     r_enable;
    logic [N_DATA_BITS-1:0]   r_rd_dat;
    logic [AW-1:0]            r_cmd_addr;
    logic [AW-1:0]            r_start;
    logic [AW-1:0]            r_fill_addr;
    logic [AW-1:0]            r_fill_end;
    logic [TW-1:0]            r_tid;
    logic [N_DATA_BITS-1:0]   r_dat;
    logic [1:0]               r_mode;
    logic [N_INIT_INC_BITS-1:0] r_inc;
    logic [N_TIMER_BITS-1:0]  r_timer;
    logic                     r_sim_tmo;

    logic                     w_issue;
    logic                     w_grant;
    logic                     w_tid_ok;
    logic                     w_addr_ok;
    logic                     w_range_ok;
    logic                     w_last;
    logic                     w_tmo_hit;
    logic                     w_nxt_req;
    logic [N_TIMER_BITS-1:0]  w_timer_inc;
    logic [AW-1:0]            w_cmd_limit;
    logic [N_DATA_BITS-1:0]   w_inc_dat;
    logic [N_DATA_BITS-1:0]   w_wdat;

    // Status code reported for a given controller state.
    function automatic logic [2:0] stat_of(input state_t s, input logic [2:0] err);
        case (s)
            POWERDOWN: stat_of = ST_PDN;
            READY:     stat_of = ST_RDY;
            ERROR:     stat_of = err;
            default:   stat_of = ST_BSY;
        endcase
    endfunction

    assign w_issue     = io.wr_stb && (io.reg_addr == CMND_ADDRESS);
    assign w_grant     = io.grant && !r_sim_tmo;
    assign w_tid_ok    = ({1'b0, io.cmnd_table_id} < (TW+1)'(N_TABLES));
    assign w_cmd_limit = io.addr_limit[io.cmnd_table_id*AW +: AW];
    assign w_addr_ok   = w_tid_ok && (io.cmnd_addr <= w_cmd_limit);
    assign w_range_ok  = w_addr_ok && (r_start <= io.cmnd_addr);
    assign w_last      = (r_fill_addr == r_fill_end);
    assign w_timer_inc = r_timer + N_TIMER_BITS'(1);
    // The watchdog fires on the stalled cycle that would take the timer to all-ones.
    assign w_tmo_hit   = r_sw_cs && !w_grant && (w_timer_inc == {N_TIMER_BITS{1'b1}});
    assign w_nxt_req   = (w_nxt_state == DO_READ) || (w_nxt_state == DO_WRITE) ||
                         (w_nxt_state == DO_FILL);

    // Next-state and error-code decode.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_err   = r_err_code;
        case (r_state)
            POWERDOWN: begin
                if (w_issue && (io.cmnd_op == OP_ENABLE)) w_nxt_state = READY;
                else                                     w_nxt_state = POWERDOWN;
            end
            READY: begin
                if (w_issue) begin
                    case (io.cmnd_op)
                        OP_NOP, OP_ENABLE, OP_SET_START, OP_SIM_TMO, OP_ACK_ERROR: begin
                            w_nxt_state = READY;
                        end
                        OP_READ: begin
                            if (w_addr_ok) w_nxt_state = DO_READ;
                            else begin w_nxt_state = ERROR; w_nxt_err = ST_NXM; end
                        end
                        OP_WRITE: begin
                            if (w_addr_ok) w_nxt_state = DO_WRITE;
                            else begin w_nxt_state = ERROR; w_nxt_err = ST_NXM; end
                        end
                        OP_RESET: begin
                            if (w_tid_ok) w_nxt_state = DO_FILL;
                            else begin w_nxt_state = ERROR; w_nxt_err = ST_NXM; end
                        end
                        OP_INIT, OP_INIT_INC: begin
                            if (w_range_ok) w_nxt_state = DO_FILL;
                            else begin w_nxt_state = ERROR; w_nxt_err = ST_NXM; end
                        end
                        OP_DISABLE: w_nxt_state = POWERDOWN;
                        default: begin w_nxt_state = ERROR; w_nxt_err = ST_UOP; end
                    endcase
                end else begin
                    w_nxt_state = READY;
                end
            end
            DO_READ, READ_DONE, DO_WRITE, DO_FILL: begin
                if (w_issue && (io.cmnd_op != OP_SIM_TMO)) begin
                    w_nxt_state = ERROR;
                    w_nxt_err   = ST_OVR;
                end else if (w_tmo_hit) begin
                    w_nxt_state = ERROR;
                    w_nxt_err   = ST_TMO;
                end else if (r_state == READ_DONE) begin
                    w_nxt_state = READY;
                end else if (w_grant) begin
                    if (r_state == DO_READ)                          w_nxt_state = READ_DONE;
                    else if ((r_state == DO_WRITE) || w_last)        w_nxt_state = READY;
                    else                                             w_nxt_state = r_state;
                end else begin
                    w_nxt_state = r_state;
                end
            end
            ERROR: begin
                if (w_issue && (io.cmnd_op == OP_ACK_ERROR)) w_nxt_state = READY;
                else                                        w_nxt_state = ERROR;
            end
            default: w_nxt_state = READY;
        endcase
    end

    // Write data: fixed pattern for RESET, incrementing low field for INIT_INC.
    always_comb begin
        w_inc_dat = r_dat;
        w_inc_dat[N_INIT_INC_BITS-1:0] = r_dat[N_INIT_INC_BITS-1:0] + r_inc;
        w_wdat = r_dat;
        if (r_state == DO_FILL) begin
            case (r_mode)
                MODE_RESET: w_wdat = RESET_DATA;
                MODE_INC:   w_wdat = w_inc_dat;
                default:    w_wdat = r_dat;
            endcase
        end else begin
            w_wdat = r_dat;
        end
    end

    // FSM state and latched error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= READY;
            r_err_code <= ST_RDY;
        end else begin
            r_state    <= w_nxt_state;
            r_err_code <= w_nxt_err;
        end
    end

    // Registered status and port qualifiers, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat   <= ST_RDY;
            r_sw_cs  <= 1'b0;
            r_sw_we  <= 1'b0;
            r_enable <= 1'b1;
        end else begin
            r_stat   <= stat_of(w_nxt_state, w_nxt_err);
            r_sw_cs  <= w_nxt_req;
            r_sw_we  <= (w_nxt_state == DO_WRITE) || (w_nxt_state == DO_FILL);
            r_enable <= (w_nxt_state != POWERDOWN);
        end
    end

    // Command latches, fill sequencing, watchdog and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_addr  <= {AW{1'b0}};
            r_start     <= {AW{1'b0}};
            r_fill_addr <= {AW{1'b0}};
            r_fill_end  <= {AW{1'b0}};
            r_tid       <= {TW{1'b0}};
            r_dat       <= {N_DATA_BITS{1'b0}};
            r_mode      <= MODE_RESET;
            r_inc       <= {N_INIT_INC_BITS{1'b0}};
            r_timer     <= {N_TIMER_BITS{1'b0}};
            r_sim_tmo   <= 1'b0;
            r_rd_dat    <= {N_DATA_BITS{1'b0}};
        end else begin
            if ((r_state == READY) && w_issue) begin
                r_cmd_addr <= io.cmnd_addr;
                r_tid      <= io.cmnd_table_id;
                r_dat      <= io.wr_dat;
                r_inc      <= {N_INIT_INC_BITS{1'b0}};
                if (io.cmnd_op == OP_RESET) begin
                    r_fill_addr <= {AW{1'b0}};
                    r_fill_end  <= w_cmd_limit;
                    r_mode      <= MODE_RESET;
                end else begin
                    r_fill_addr <= r_start;
                    r_fill_end  <= io.cmnd_addr;
                    r_mode      <= (io.cmnd_op == OP_INIT_INC) ? MODE_INC : MODE_INIT;
                end
                if (io.cmnd_op == OP_SET_START) r_start <= io.cmnd_addr;
            end else if ((r_state == DO_FILL) && w_grant) begin
                r_inc <= r_inc + N_INIT_INC_BITS'(1);
                if (!w_last) r_fill_addr <= r_fill_addr + AW'(1);
            end

            if (r_sw_cs && !w_grant && (w_nxt_state == r_state)) r_timer <= w_timer_inc;
            else                                                  r_timer <= {N_TIMER_BITS{1'b0}};

            // Simulated timeout keeps grant masked until the watchdog has fired once.
            if (w_tmo_hit) begin
                r_sim_tmo <= 1'b0;
            end else if (w_issue && (io.cmnd_op == OP_SIM_TMO) &&
                         (r_state != POWERDOWN) && (r_state != ERROR)) begin
                r_sim_tmo <= 1'b1;
            end

            if ((r_state == READ_DONE) && (w_nxt_state == READY)) r_rd_dat <= io.sw_rdat;
            else if ((r_state == POWERDOWN) && w_issue)           r_rd_dat <= io.wr_dat;
        end
    end

    assign io.rd_dat        = r_rd_dat;
    assign io.stat_code     = r_stat;
    assign io.stat_table_id = r_tid;
    assign io.stat_addr     = io.addr_limit[r_tid*AW +: AW];
    assign io.enable        = r_enable;
    assign io.sw_cs         = r_sw_cs;
    assign io.sw_we         = r_sw_we;
    assign io.sw_tid        = r_tid;
    assign io.sw_add        = (r_state == DO_FILL) ? r_fill_addr : r_cmd_addr;
    assign io.sw_wdat       = w_wdat;
    assign io.yield         = r_timer[N_TIMER_BITS-1];
endmodule

// File: tb/tb_nx_indirect_access_mt_cntrl.sv
// Scoreboard bench for nx_indirect_access_mt_cntrl: expected SRAM accesses are queued as
// commands are driven and matched against granted sw_cs cycles observed on the memory port.
module tb_nx_indirect_access_mt_cntrl;
    localparam logic [10:0] CMND = 11'h40C;
    localparam logic [3:0] OP_READ = 4'd1, OP_WRITE = 4'd2, OP_ENABLE = 4'd3, OP_DISABLE = 4'd4,
                           OP_RESET = 4'd5, OP_INIT = 4'd6, OP_INIT_INC = 4'd7,
                           OP_SET_START = 4'd8, OP_SIM_TMO = 4'd14, OP_ACK = 4'd15;
    localparam logic [2:0] RDY = 3'd0, BSY = 3'd1, TMO = 3'd2, OVR = 3'd3, NXM = 3'd4,
                           UOP = 3'd5, PDN = 3'd7;

    typedef struct packed {
        logic        we;
        logic [1:0]  tid;
        logic [9:0]  addr;
        logic [63:0] dat;
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic        mon_mask;
    int          n_checks;
    int          n_fail;
    int          n_unexp;
    sb_entry_t   exp_q[$];
    logic [63:0] mem [0:3][0:1023];
    logic [63:0] d_tmp;

    nx_indirect_access_mt_cntrl_if #(.N_REG_ADDR_BITS(11), .N_TABLES(4), .N_ENTRIES(1024),
                                     .N_DATA_BITS(64)) io ();

    nx_indirect_access_mt_cntrl dut (.clk(clk), .rst_n(rst_n), .io(io));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory model and scoreboard: every granted request must match the queue head.
    always @(posedge clk) begin : mon
        sb_entry_t e;
        if (io.sw_cs && io.grant && !mon_mask) begin
            if (exp_q.size() == 0) begin
                n_unexp <= n_unexp + 1;
            end else begin
                e = exp_q.pop_front();
                check_value("acc_we", {63'd0, io.sw_we}, {63'd0, e.we});
                check_value("acc_tid", {62'd0, io.sw_tid}, {62'd0, e.tid});
                check_value("acc_addr", {54'd0, io.sw_add}, {54'd0, e.addr});
                if (e.we) check_value("acc_wdat", io.sw_wdat, e.dat);
            end
            if (io.sw_we) begin
                mem[io.sw_tid][io.sw_add] <= io.sw_wdat;
                io.sw_rdat <= {$urandom, $urandom};
            end else begin
                io.sw_rdat <= mem[io.sw_tid][io.sw_add];
            end
        end else begin
            io.sw_rdat <= {$urandom, $urandom};
        end
    end

    // Drive one command write at a negedge; fields are scrambled afterwards to prove latching.
    task automatic issue(input logic [3:0] op, input logic [9:0] a, input logic [1:0] t,
                         input logic [63:0] d);
        io.wr_stb = 1'b1; io.reg_addr = CMND; io.cmnd_op = op;
        io.cmnd_addr = a; io.cmnd_table_id = t; io.wr_dat = d;
        @(negedge clk);
        io.wr_stb = 1'b0; io.reg_addr = 11'($urandom); io.cmnd_op = 4'($urandom);
        io.cmnd_addr = 10'($urandom); io.cmnd_table_id = 2'($urandom);
        io.wr_dat = {$urandom, $urandom};
    endtask

    task automatic push(input logic we, input logic [1:0] t, input logic [9:0] a,
                        input logic [63:0] d);
        sb_entry_t e;
        e.we = we; e.tid = t; e.addr = a; e.dat = d;
        exp_q.push_back(e);
    endtask

    // Wait for RDY with a random grant pattern, bounded by a cycle budget.
    task automatic wait_rdy(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (io.stat_code == RDY) break;
            io.grant = 1'($urandom);
            @(negedge clk);
        end
        io.grant = 1'b1;
        check_value(tag, {61'd0, io.stat_code}, {61'd0, RDY});
    endtask

    task automatic check_sb(input string tag);
        check_value({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check_value({tag, "_unexpected"}, 64'(n_unexp), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0; n_unexp = 0; mon_mask = 1'b0;
        io.wr_stb = 1'b0; io.reg_addr = 11'd0; io.cmnd_op = 4'd0; io.cmnd_addr = 10'd0;
        io.cmnd_table_id = 2'd0; io.wr_dat = 64'd0; io.grant = 1'b0;
        io.addr_limit = {10'd1023, 10'd20, 10'd100, 10'd15};
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_value("rst_stat", {61'd0, io.stat_code}, {61'd0, RDY});
        check_value("rst_ctl", {59'd0, io.sw_cs, io.sw_we, io.yield, io.enable, 1'b0}, 64'd2);
        check_value("rst_rd_dat", io.rd_dat, 64'd0);
        check_value("rst_tid", {62'd0, io.stat_table_id}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // CSR write to another address is not a command.
        io.wr_stb = 1'b1; io.reg_addr = 11'h408; io.cmnd_op = OP_WRITE;
        @(negedge clk);
        io.wr_stb = 1'b0;
        check_value("other_addr", {62'd0, io.sw_cs, io.stat_code == BSY}, 64'd0);

        // WRITE then READ back with grant held high.
        io.grant = 1'b1;
        push(1'b1, 2'd2, 10'd5, 64'hA5);
        issue(OP_WRITE, 10'd5, 2'd2, 64'hA5);
        check_value("wr_bsy", {61'd0, io.stat_code}, {61'd0, BSY});
        check_value("wr_cs_we", {62'd0, io.sw_cs, io.sw_we}, 64'd3);
        @(negedge clk);
        check_value("wr_done", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, RDY});
        push(1'b0, 2'd2, 10'd5, 64'd0);
        issue(OP_READ, 10'd5, 2'd2, 64'd0);
        check_value("rd_cs", {62'd0, io.sw_cs, io.sw_we}, 64'd2);
        @(negedge clk);
        check_value("rd_g1", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, BSY});
        @(negedge clk);
        check_value("rd_dat", io.rd_dat, 64'hA5);
        check_value("rd_rdy", {61'd0, io.stat_code}, {61'd0, RDY});
        check_value("stat_tid", {62'd0, io.stat_table_id}, 64'd2);
        check_value("stat_addr", {54'd0, io.stat_addr}, 64'd20);
        check_sb("rw");

        // INIT_INC over 3..6 and a wrapping INIT_INC over 7..9.
        issue(OP_SET_START, 10'd3, 2'd1, 64'd0);
        check_value("set_start", {61'd0, io.stat_code}, {61'd0, RDY});
        for (int i = 0; i < 4; i++) push(1'b1, 2'd1, 10'(3 + i), 64'h100 + 64'(i));
        issue(OP_INIT_INC, 10'd6, 2'd1, 64'h100);
        for (int i = 0; i < 4; i++) begin
            check_value("inc_add", {53'd0, io.sw_cs, io.sw_add}, {53'd0, 1'b1, 10'(3 + i)});
            @(negedge clk);
        end
        check_value("inc_rdy", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, RDY});
        issue(OP_SET_START, 10'd7, 2'd3, 64'd0);
        d_tmp = 64'hABCD_0000_0000_12FE;
        for (int i = 0; i < 3; i++)
            push(1'b1, 2'd3, 10'(7 + i), {d_tmp[63:8], d_tmp[7:0] + 8'(i)});
        issue(OP_INIT_INC, 10'd9, 2'd3, d_tmp);
        wait_rdy("inc_wrap_rdy", 20);
        push(1'b0, 2'd1, 10'd4, 64'd0);
        issue(OP_READ, 10'd4, 2'd1, 64'd0);
        repeat (2) @(negedge clk);
        check_value("inc_readback", io.rd_dat, 64'h101);
        check_sb("init_inc");

        // Address errors, ignored commands and unsupported opcode.
        issue(OP_READ, 10'd21, 2'd2, 64'd0);
        check_value("nxm", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, NXM});
        issue(OP_READ, 10'd5, 2'd2, 64'd0);
        check_value("nxm_hold", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, NXM});
        issue(OP_ACK, 10'd0, 2'd0, 64'd0);
        check_value("nxm_ack", {61'd0, io.stat_code}, {61'd0, RDY});
        issue(OP_SET_START, 10'd9, 2'd3, 64'd0);
        issue(OP_INIT, 10'd8, 2'd3, 64'd1);
        check_value("nxm_range", {61'd0, io.stat_code}, {61'd0, NXM});
        issue(OP_ACK, 10'd0, 2'd0, 64'd0);
        issue(4'd9, 10'd0, 2'd0, 64'd0);
        check_value("uop", {61'd0, io.stat_code}, {61'd0, UOP});
        issue(OP_ACK, 10'd0, 2'd0, 64'd0);
        check_sb("errors");

        // Simulated timeout: grant held high but masked, watchdog fires after 15 stalls.
        issue(OP_SIM_TMO, 10'd0, 2'd0, 64'd0);
        mon_mask = 1'b1;
        issue(OP_WRITE, 10'd1, 2'd0, 64'h77);
        for (int k = 1; k <= 15; k++) begin
            check_value("tmo_cs_yield", {61'd0, io.sw_cs, io.yield, io.stat_code == BSY},
                        {61'd0, 1'b1, (k - 1) >= 8, 1'b1});
            @(negedge clk);
        end
        check_value("tmo", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, TMO});
        mon_mask = 1'b0;
        issue(OP_ACK, 10'd0, 2'd0, 64'd0);
        push(1'b1, 2'd0, 10'd1, 64'h88);
        issue(OP_WRITE, 10'd1, 2'd0, 64'h88);
        @(negedge clk);
        check_value("tmo_cleared", {61'd0, io.stat_code}, {61'd0, RDY});

        // Full RESET of table 0 with random grant, then RESET abandoned by a WRITE.
        for (int i = 0; i < 16; i++) push(1'b1, 2'd0, 10'(i), 64'd0);
        issue(OP_RESET, 10'd0, 2'd0, 64'hFFFF);
        wait_rdy("reset_rdy", 200);
        check_sb("reset");
        for (int i = 0; i < 4; i++) push(1'b1, 2'd0, 10'(i), 64'd0);
        issue(OP_RESET, 10'd0, 2'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check_value("ovr_add", {54'd0, io.sw_add}, 64'(i));
            @(negedge clk);
        end
        issue(OP_WRITE, 10'd2, 2'd1, 64'd9);
        check_value("ovr", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, OVR});
        check_sb("ovr");
        issue(OP_ACK, 10'd0, 2'd0, 64'd0);

        // Powerdown: only ENABLE acts, rd_dat tracks command data.
        issue(OP_DISABLE, 10'd0, 2'd0, 64'd0);
        check_value("pdn", {60'd0, io.enable, io.stat_code}, {60'd0, 1'b0, PDN});
        issue(OP_READ, 10'd5, 2'd2, 64'h5555);
        check_value("pdn_rd_dat", io.rd_dat, 64'h5555);
        check_value("pdn_hold", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, PDN});
        issue(OP_ENABLE, 10'd0, 2'd0, 64'h5555);
        check_value("enable", {60'd0, io.enable, io.stat_code}, {60'd0, 1'b1, RDY});
        check_sb("pdn");

        // Asynchronous reset in the middle of an INIT.
        issue(OP_SET_START, 10'd0, 2'd0, 64'd0);
        mon_mask = 1'b1;
        issue(OP_INIT, 10'd9, 2'd3, 64'h42);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("arst_stat", {61'd0, io.stat_code}, {61'd0, RDY});
        check_value("arst_ctl", {59'd0, io.sw_cs, io.sw_we, io.yield, io.enable, 1'b0}, 64'd2);
        check_value("arst_out", {io.rd_dat[61:0], io.stat_table_id}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_mask = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_value("arst_idle", {60'd0, io.sw_cs, io.stat_code}, {60'd0, 1'b0, RDY});
        end
        check_sb("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
